alaw_frame_serializer: RTL and testbench

//   Downstream of the A-law compressor. Buffers 15-bit compressed samples in a

---
 rtl/alaw_link_pkg.sv | 20 ++
 rtl/sample_fifo.sv | 49 ++++
 rtl/alaw_frame_serializer.sv | 158 +++++++++++++++
 tb/tb_alaw_frame_serializer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alaw_link_pkg.sv
// Shared constants and FSM encoding for the A-law serial link (serializer and deframer).
`default_nettype none

package alaw_link_pkg;

   localparam int               LINK_DATA_W       = 15;
   localparam int               SYNC_W            = 3;
   localparam logic [SYNC_W-1:0] LINK_SYNC_PATTERN = 3'b101;
   localparam int               FRAME_BITS        = SYNC_W + LINK_DATA_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SYNC   = 2'd1,
      ST_DATA   = 2'd2,
      ST_PARITY = 2'd3
   } link_state_e;

endpackage

`default_nettype wire

// File: rtl/sample_fifo.sv
// Small synchronous FIFO; pointers carry an extra wrap bit so full/empty come from a compare.
`default_nettype none

module sample_fifo #(
   parameter int WIDTH = 15,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_wr_en;
   logic             w_rd_en;

   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
   assign w_wr_en = i_push && !o_full;
   assign w_rd_en = i_pop && !o_empty;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   // Storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
   end

endmodule

`default_nettype wire

// File: rtl/alaw_frame_serializer.sv
// Buffers compressed A-law samples and sends each as sync header + MSB-first data + even parity.
`default_nettype none

module alaw_frame_serializer
   import alaw_link_pkg::*;
#(
   parameter int                DATA_W       = LINK_DATA_W,
   parameter int                FIFO_DEPTH   = 4,
   parameter int                CLKS_PER_BIT = 1,
   parameter logic [SYNC_W-1:0] SYNC_PATTERN = LINK_SYNC_PATTERN
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] compressed_in,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              tx_bit,
   output logic              tx_active,
   output logic              frame_done,
   output logic              overflow
);

   localparam int               TMR_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int               CNT_W    = $clog2(DATA_W);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(CLKS_PER_BIT - 1);

   link_state_e       r_state, w_state_nxt;
   logic [TMR_W-1:0]  r_tmr, w_tmr_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic [DATA_W-1:0] r_shift, w_shift_nxt;
   logic              r_parity, w_parity_nxt;
   logic              r_tx_bit, r_tx_active, r_frame_done, r_overflow;

   logic              w_full, w_empty, w_push, w_pop, w_bit_end;
   logic [DATA_W-1:0] w_rdata;
   logic [SYNC_W-1:0] w_sync_sh;
   logic              w_line_bit;

   // Full is sampled before any pop in the same cycle, so a push at full is always dropped.
   assign w_push   = in_valid && !w_full;
   assign in_ready = !w_full;

   sample_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (w_push),
      .i_wdata (compressed_in),
      .i_pop   (w_pop),
      .o_rdata (w_rdata),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_bit_end = (r_tmr == '0);
   assign w_sync_sh = SYNC_PATTERN << r_cnt;

   always_comb begin
      w_state_nxt  = r_state;
      w_tmr_nxt    = r_tmr;
      w_cnt_nxt    = r_cnt;
      w_shift_nxt  = r_shift;
      w_parity_nxt = r_parity;
      w_pop        = 1'b0;
      w_line_bit   = 1'b0;

      if (r_state != ST_IDLE && !w_bit_end) w_tmr_nxt = r_tmr - TMR_W'(1);

      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_shift_nxt  = w_rdata;
               w_parity_nxt = ^w_rdata;
               w_tmr_nxt    = TMR_LOAD;
               w_cnt_nxt    = '0;
               w_state_nxt  = ST_SYNC;
            end
         end
         ST_SYNC: begin
            w_line_bit = w_sync_sh[SYNC_W-1];
            if (w_bit_end) begin
               w_tmr_nxt = TMR_LOAD;
               if (r_cnt == CNT_W'(SYNC_W - 1)) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = ST_DATA;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
         end
         ST_DATA: begin
            w_line_bit = r_shift[DATA_W-1];
            if (w_bit_end) begin
               w_tmr_nxt   = TMR_LOAD;
               w_shift_nxt = r_shift << 1;
               if (r_cnt == CNT_W'(DATA_W - 1)) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = ST_PARITY;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
         end
         ST_PARITY: begin
            w_line_bit = r_parity;
            if (w_bit_end) begin
               // Chain straight into the next frame so the line has no idle gap.
               if (!w_empty) begin
                  w_pop        = 1'b1;
                  w_shift_nxt  = w_rdata;
                  w_parity_nxt = ^w_rdata;
                  w_tmr_nxt    = TMR_LOAD;
                  w_cnt_nxt    = '0;
                  w_state_nxt  = ST_SYNC;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_tmr        <= '0;
         r_cnt        <= '0;
         r_shift      <= '0;
         r_parity     <= 1'b0;
         r_tx_bit     <= 1'b0;
         r_tx_active  <= 1'b0;
         r_frame_done <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_tmr        <= w_tmr_nxt;
         r_cnt        <= w_cnt_nxt;
         r_shift      <= w_shift_nxt;
         r_parity     <= w_parity_nxt;
         r_tx_bit     <= w_line_bit;
         r_tx_active  <= (r_state != ST_IDLE);
         r_frame_done <= (r_state == ST_PARITY) && w_bit_end;
         if (in_valid && w_full) r_overflow <= 1'b1;
      end
   end

   assign tx_bit     = r_tx_bit;
   assign tx_active  = r_tx_active;
   assign frame_done = r_frame_done;
   assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_alaw_frame_serializer.sv
// Directed bench for alaw_frame_serializer: one-bit-per-clock and four-clocks-per-bit instances.
`default_nettype none

module tb_alaw_frame_serializer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [14:0] d1, d4;
   logic        v1, v4;
   logic        rdy1, bit1, act1, done1, ovf1;
   logic        rdy4, bit4, act4, done4, ovf4;

   int n_vec  = 0;
   int n_fail = 0;

   logic q1[$], f1[$], q4[$], f4[$];
   logic eq[$], ed[$];

   always #5 clk = ~clk;

   alaw_frame_serializer #(.CLKS_PER_BIT(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .compressed_in(d1), .in_valid(v1),
      .in_ready(rdy1), .tx_bit(bit1), .tx_active(act1), .frame_done(done1), .overflow(ovf1)
   );

   alaw_frame_serializer #(.CLKS_PER_BIT(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .compressed_in(d4), .in_valid(v4),
      .in_ready(rdy4), .tx_bit(bit4), .tx_active(act4), .frame_done(done4), .overflow(ovf4)
   );

   // Line recorders: one entry per active line cycle.
   always @(posedge clk) begin
      #1;
      if (act1) begin q1.push_back(bit1); f1.push_back(done1); end
      if (act4) begin q4.push_back(bit4); f4.push_back(done4); end
   end

   typedef struct {
      logic [14:0] word;
      logic [18:0] frame;
   } vec_t;

   vec_t tbl[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_all();
      q1.delete(); f1.delete(); q4.delete(); f4.delete(); eq.delete(); ed.delete();
   endtask

   function automatic logic [18:0] mk_frame(input logic [14:0] w);
      return {3'b101, w, ^w};
   endfunction

   task automatic push_frame(input logic [18:0] f, input int cpb);
      for (int b = 18; b >= 0; b--)
         for (int r = 0; r < cpb; r++) begin
            eq.push_back(f[b]);
            ed.push_back(b == 0 && r == cpb - 1);
         end
   endtask

   task automatic wait_line_done(input string name, input int limit);
      bit seen, fin;
      seen = act1 | act4;
      fin  = 1'b0;
      for (int k = 0; k < limit && !fin; k++) begin
         tick();
         if (act1 || act4) seen = 1'b1;
         else if (seen) fin = 1'b1;
      end
      check({name, " finished"}, 32'(fin), 32'd1);
   endtask

   task automatic compare_line(input string name, input bit use4);
      logic aq[$], af[$];
      int   nb, nd, n;
      if (use4) begin aq = q4; af = f4; end
      else      begin aq = q1; af = f1; end
      check({name, " length"}, aq.size(), eq.size());
      n  = (aq.size() < eq.size()) ? aq.size() : eq.size();
      nb = 0;
      nd = 0;
      for (int i = 0; i < n; i++) begin
         if (aq[i] !== eq[i]) nb++;
         if (af[i] !== ed[i]) nd++;
      end
      check({name, " bit errors"}, nb, 0);
      check({name, " frame_done errors"}, nd, 0);
   endtask

   task automatic do_reset();
      #3 reset_n = 1'b0;
      #10 reset_n = 1'b1;
      tick();
   endtask

   initial begin
      logic [14:0] words[7];
      logic        prev_rdy;
      int          early_rdy;
      bit          got_done;

      tbl[0] = '{15'h7FFF, 19'b101_111111111111111_1};
      tbl[1] = '{15'h0000, 19'b101_000000000000000_0};
      tbl[2] = '{15'h1234, 19'b101_001001000110100_1};
      tbl[3] = '{15'h5555, 19'b101_101010101010101_0};
      tbl[4] = '{15'h0001, 19'b101_000000000000001_1};
      tbl[5] = '{15'h4000, 19'b101_100000000000000_1};
      tbl[6] = '{15'h2AAA, 19'b101_010101010101010_1};

      reset_n = 1'b0; v1 = 1'b0; v4 = 1'b0; d1 = '0; d4 = '0;
      #12;
      check("reset tx_bit",     {bit1, bit4},   2'b00);
      check("reset tx_active",  {act1, act4},   2'b00);
      check("reset frame_done", {done1, done4}, 2'b00);
      check("reset overflow",   {ovf1, ovf4},   2'b00);
      check("reset in_ready",   {rdy1, rdy4},   2'b11);
      #5 reset_n = 1'b1;
      tick();

      // Single frames, one clock per bit, including two-cycle start latency.
      for (int i = 0; i < 7; i++) begin
         logic a_n1, a_n2, b_n2;
         clear_all();
         v1 = 1'b1; d1 = tbl[i].word;
         tick();
         v1 = 1'b0;
         tick(); a_n1 = act1;
         tick(); a_n2 = act1; b_n2 = bit1;
         check($sformatf("vec%0d latency", i), {a_n1, a_n2, b_n2}, 3'b011);
         wait_line_done($sformatf("vec%0d", i), 100);
         push_frame(tbl[i].frame, 1);
         compare_line($sformatf("vec%0d", i), 1'b0);
      end

      // Four clocks per bit.
      clear_all();
      v4 = 1'b1; d4 = 15'h5555;
      tick();
      v4 = 1'b0;
      wait_line_done("cpb4", 200);
      push_frame(19'b101_101010101010101_0, 4);
      compare_line("cpb4", 1'b1);

      // Three back-to-back frames.
      clear_all();
      v1 = 1'b1; d1 = 15'h0000; tick();
      d1 = 15'h7FFF; tick();
      d1 = 15'h1234; tick();
      v1 = 1'b0;
      wait_line_done("b2b", 200);
      push_frame(19'b101_000000000000000_0, 1);
      push_frame(19'b101_111111111111111_1, 1);
      push_frame(19'b101_001001000110100_1, 1);
      compare_line("b2b", 1'b0);

      // Seven pushes into a 4-deep FIFO: five sent, two dropped.
      clear_all();
      for (int i = 0; i < 7; i++) words[i] = 15'(((i + 1) << 8) | ((i + 1) * 17));
      for (int i = 0; i < 7; i++) begin
         v1 = 1'b1; d1 = words[i];
         tick();
      end
      v1 = 1'b0;
      check("burst overflow", ovf1, 1'b1);
      check("burst in_ready full", rdy1, 1'b0);
      early_rdy = 0;
      prev_rdy  = rdy1;
      got_done  = 1'b0;
      for (int k = 0; k < 40 && !got_done; k++) begin
         tick();
         if (done1) begin
            got_done = 1'b1;
            check("burst in_ready after 2nd pop", {prev_rdy, rdy1}, 2'b01);
         end else begin
            if (rdy1) early_rdy++;
            prev_rdy = rdy1;
         end
      end
      check("burst first frame_done seen", 32'(got_done), 32'd1);
      check("burst in_ready early", early_rdy, 0);
      wait_line_done("burst", 300);
      for (int i = 0; i < 5; i++) push_frame(mk_frame(words[i]), 1);
      compare_line("burst", 1'b0);

      // Push at full exactly on the end-of-parity pop cycle.
      do_reset();
      clear_all();
      for (int i = 0; i < 5; i++) begin
         v1 = 1'b1; d1 = words[i];
         tick();
      end
      v1 = 1'b0;
      check("popcycle overflow before", ovf1, 1'b0);
      check("popcycle full before", rdy1, 1'b0);
      repeat (15) tick();
      v1 = 1'b1; d1 = 15'h7ABC;
      tick();
      v1 = 1'b0;
      check("popcycle align frame_done", done1, 1'b1);
      check("popcycle overflow", ovf1, 1'b1);
      check("popcycle in_ready after pop", rdy1, 1'b1);
      v1 = 1'b1; d1 = 15'h0F0F;
      tick();
      v1 = 1'b0;
      check("popcycle count was 3", rdy1, 1'b0);
      wait_line_done("popcycle", 300);
      for (int i = 0; i < 5; i++) push_frame(mk_frame(words[i]), 1);
      push_frame(mk_frame(15'h0F0F), 1);
      compare_line("popcycle", 1'b0);

      // Reset in the middle of the data bits, with a second word queued.
      clear_all();
      v1 = 1'b1; d1 = 15'h7FFF; tick();
      v1 = 1'b0;
      repeat (8) tick();
      v1 = 1'b1; d1 = 15'h1111; tick();
      v1 = 1'b0;
      check("midreset pre line", {act1, bit1}, 2'b11);
      #3 reset_n = 1'b0;
      #1;
      check("midreset tx_bit",    bit1, 1'b0);
      check("midreset tx_active", act1, 1'b0);
      check("midreset overflow",  ovf1, 1'b0);
      check("midreset in_ready",  rdy1, 1'b1);
      #10 reset_n = 1'b1;
      clear_all();
      repeat (40) tick();
      check("midreset no bits after release", q1.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected finish");
      $fatal(1);
   end

endmodule

`default_nettype wire
